// File: rtl/mcp3_arb05.sv
// Five-requester round-robin arbiter for one shared AFU resource, with done/hold-limit release.
// Optional one-hot grant integrity checker enabled by MCP3_ARB05_ONEHOT_CHK_EN.
module mcp3_arb05 #(
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic       done,
  output logic [4:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_id,
  output logic       hold_timeout,
  output logic       gnt_error
);

  localparam int unsigned N_REQ = 5;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned SUM_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam bit HOLD_EN = (HOLD_MAX != 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [ID_W-1:0]    gnt_id_nxt;
  logic               gnt_valid_nxt;
  logic               hold_timeout_nxt;

  logic [ID_W-1:0]    last_idx_c;
  logic [ID_W-1:0]    win_idx_c;
  logic               win_found_c;
  logic [2*N_REQ-1:0] req_dbl_c;
  logic [N_REQ-1:0]   req_rot_c;
  logic [SUM_W-1:0]   win_sum_c;

  // Binary index of the previous owner.
  always_comb begin
    last_idx_c = ID_W'(N_REQ - 1);
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (last[i]) last_idx_c = ID_W'(i);
    end
  end

  // Rotate req so bit 0 is the requester just after the previous owner, then take the first set bit.
  always_comb begin
    req_dbl_c   = {req, req};
    req_rot_c   = N_REQ'(req_dbl_c >> (SUM_W'(last_idx_c) + SUM_W'(1)));
    win_found_c = 1'b0;
    win_sum_c   = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!win_found_c && req_rot_c[j]) begin
        win_found_c = 1'b1;
        win_sum_c   = SUM_W'(last_idx_c) + SUM_W'(1) + SUM_W'(j);
      end
    end
    if (win_sum_c >= SUM_W'(N_REQ)) win_sum_c = win_sum_c - SUM_W'(N_REQ);
    win_idx_c = ID_W'(win_sum_c);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last         <= 5'b10000;
      cnt          <= '0;
      gnt          <= '0;
      gnt_id       <= '0;
      gnt_valid    <= 1'b0;
      hold_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      last         <= last_nxt;
      cnt          <= cnt_nxt;
      gnt          <= gnt_nxt;
      gnt_id       <= gnt_id_nxt;
      gnt_valid    <= gnt_valid_nxt;
      hold_timeout <= hold_timeout_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    last_nxt         = last;
    cnt_nxt          = cnt;
    gnt_nxt          = gnt;
    gnt_id_nxt       = gnt_id;
    gnt_valid_nxt    = gnt_valid;
    hold_timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_nxt       = '0;
        gnt_id_nxt    = '0;
        gnt_valid_nxt = 1'b0;
        if (win_found_c) begin
          state_nxt     = GRANT;
          gnt_nxt       = N_REQ'(1) << win_idx_c;
          gnt_id_nxt    = win_idx_c;
          gnt_valid_nxt = 1'b1;
          last_nxt      = N_REQ'(1) << win_idx_c;
          cnt_nxt       = '0;
        end
      end
      GRANT: begin
        if (done || (HOLD_EN && (cnt == HOLD_LAST))) begin
          // done wins over a simultaneous limit hit, so no timeout pulse then.
          state_nxt        = IDLE;
          gnt_nxt          = '0;
          gnt_id_nxt       = '0;
          gnt_valid_nxt    = 1'b0;
          hold_timeout_nxt = !done;
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef MCP3_ARB05_ONEHOT_CHK_EN
  logic onehot_bad_c;

  // Grant must be exactly one-hot while in GRANT and all-zero otherwise.
  always_comb begin
    onehot_bad_c = 1'b0;
    if (state == GRANT) begin
      onehot_bad_c = (gnt == '0) || ((gnt & (gnt - N_REQ'(1))) != '0);
    end else begin
      onehot_bad_c = (gnt != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_error <= 1'b0;
    end else begin
      gnt_error <= gnt_error | onehot_bad_c;
    end
  end
`else
  assign gnt_error = 1'b0;
`endif

endmodule

// File: tb/tb_mcp3_arb05.sv
// Directed self-checking bench for mcp3_arb05: default hold limit plus a HOLD_MAX=4 instance.
module tb_mcp3_arb05;

  logic       clock;
  logic       reset;
  logic [4:0] req_a, req_b;
  logic       done_a, done_b;
  logic [4:0] gnt_a, gnt_b;
  logic       gnt_valid_a, gnt_valid_b;
  logic [2:0] gnt_id_a, gnt_id_b;
  logic       hold_timeout_a, hold_timeout_b;
  logic       gnt_error_a, gnt_error_b;

  int n_checks;
  int n_fail;

  mcp3_arb05 u_dut_a (
    .clock        (clock),
    .reset        (reset),
    .req          (req_a),
    .done         (done_a),
    .gnt          (gnt_a),
    .gnt_valid    (gnt_valid_a),
    .gnt_id       (gnt_id_a),
    .hold_timeout (hold_timeout_a),
    .gnt_error    (gnt_error_a)
  );

  mcp3_arb05 #(.HOLD_MAX(4)) u_dut_b (
    .clock        (clock),
    .reset        (reset),
    .req          (req_b),
    .done         (done_b),
    .gnt          (gnt_b),
    .gnt_valid    (gnt_valid_b),
    .gnt_id       (gnt_id_b),
    .hold_timeout (hold_timeout_b),
    .gnt_error    (gnt_error_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [4:0] g, input logic [2:0] id);
    check({tag, ".gnt"}, 32'(gnt_a), 32'(g));
    check({tag, ".id"}, 32'(gnt_id_a), 32'(id));
    check({tag, ".valid"}, 32'(gnt_valid_a), 32'(g != 5'd0));
    check({tag, ".err"}, 32'(gnt_error_a), 32'd0);
  endtask

  task automatic check_b(input string tag, input logic [4:0] g, input logic [2:0] id, input logic ht);
    check({tag, ".gnt"}, 32'(gnt_b), 32'(g));
    check({tag, ".id"}, 32'(gnt_id_b), 32'(id));
    check({tag, ".valid"}, 32'(gnt_valid_b), 32'(g != 5'd0));
    check({tag, ".to"}, 32'(hold_timeout_b), 32'(ht));
  endtask

  initial begin
    logic [2:0] order [6];
    n_checks = 0;
    n_fail   = 0;
    reset  = 1'b1;
    req_a  = '0;
    req_b  = '0;
    done_a = 1'b0;
    done_b = 1'b0;
    order  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    tick();
    check_a("reset_a", 5'b00000, 3'd0);
    check("reset_a.to", 32'(hold_timeout_a), 32'd0);
    check_b("reset_b", 5'b00000, 3'd0, 1'b0);
    reset = 1'b0;

    // Basic grant, release, one idle cycle, next requester.
    req_a = 5'b00110;
    tick();
    check_a("first_grant", 5'b00010, 3'd1);
    done_a = 1'b1;
    tick();
    check_a("release_idle", 5'b00000, 3'd0);
    done_a = 1'b0;
    tick();
    check_a("second_grant", 5'b00100, 3'd2);
    done_a = 1'b1;
    req_a  = '0;
    tick();
    done_a = 1'b0;

    // Full rotation from reset with all requesting.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_a = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_a($sformatf("rr%0d", i), 5'(5'd1 << order[i]), order[i]);
      done_a = 1'b1;
      tick();
      check_a($sformatf("rr%0d_idle", i), 5'b00000, 3'd0);
      done_a = 1'b0;
    end
    req_a = '0;

    // done with no grant is ignored; idle without requests keeps the pointer on 0.
    done_a = 1'b1;
    tick();
    check_a("done_in_idle", 5'b00000, 3'd0);
    done_a = 1'b0;
    tick();
    req_a = 5'b00011;
    tick();
    check_a("ptr_kept", 5'b00010, 3'd1);
    // Owner drops req and others change: grant must hold.
    req_a = 5'b10100;
    tick();
    tick();
    check_a("hold_no_req", 5'b00010, 3'd1);
    done_a = 1'b1;
    req_a  = '0;
    tick();
    check_a("hold_release", 5'b00000, 3'd0);
    done_a = 1'b0;

    // Forced release after exactly 4 cycles.
    req_b = 5'b01000;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_b($sformatf("to_cyc%0d", c), 5'b01000, 3'd3, 1'b0);
    end
    tick();
    check_b("to_pulse", 5'b00000, 3'd0, 1'b1);
    tick();
    check_b("to_regrant", 5'b01000, 3'd3, 1'b0);

    // done on the 4th grant cycle is a normal release.
    tick();
    tick();
    tick();
    check_b("done4_pre", 5'b01000, 3'd3, 1'b0);
    done_b = 1'b1;
    tick();
    check_b("done4_rel", 5'b00000, 3'd0, 1'b0);
    done_b = 1'b0;
    tick();
    check_b("done4_regrant", 5'b01000, 3'd3, 1'b0);

    // Asynchronous reset mid-grant.
    tick();
    reset = 1'b1;
    #1;
    check_b("async_rst", 5'b00000, 3'd0, 1'b0);
    req_b = 5'b11111;
    tick();
    check_b("rst_held", 5'b00000, 3'd0, 1'b0);
    reset = 1'b0;
    tick();
    check_b("post_rst", 5'b00001, 3'd0, 1'b0);

`ifdef MCP3_ARB05_ONEHOT_CHK_EN
    check("err_clean", 32'(gnt_error_b), 32'd0);
    force u_dut_b.gnt = 5'b00011;
    tick();
    tick();
    check("err_set", 32'(gnt_error_b), 32'd1);
    release u_dut_b.gnt;
    req_b = '0;
    tick();
    tick();
    check("err_sticky", 32'(gnt_error_b), 32'd1);
    reset = 1'b1;
    #1;
    check("err_cleared", 32'(gnt_error_b), 32'd0);
    tick();
    reset = 1'b0;
`else
    check("err_tied", 32'(gnt_error_b), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
